// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and default sizes.
package mem_pkg;

  localparam int WORD_LEN_DEFAULT    = 32;
  localparam int DEPTH_WORDS_DEFAULT = 4096;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Two-read/one-write synchronous RAM with registered read ports and write-first bypass.
module mem_array #(
  parameter int WORD_LEN    = 32,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [WORD_LEN-1:0]            wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] a_raddr,
  input  logic                           a_ok,
  output logic [WORD_LEN-1:0]            a_rdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] b_raddr,
  input  logic                           b_ok,
  output logic [WORD_LEN-1:0]            b_rdata
);

  logic [WORD_LEN-1:0] mem_r [DEPTH_WORDS];
  logic [WORD_LEN-1:0] a_rdata_r;
  logic [WORD_LEN-1:0] b_rdata_r;

  // Storage write; the array itself is never reset so load-time contents survive.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read ports; a same-edge write to the read word is forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_r <= {WORD_LEN{1'b0}};
      b_rdata_r <= {WORD_LEN{1'b0}};
    end else begin
      if (!a_ok) begin
        a_rdata_r <= {WORD_LEN{1'b0}};
      end else if (we && (waddr == a_raddr)) begin
        a_rdata_r <= wdata;
      end else begin
        a_rdata_r <= mem_r[a_raddr];
      end
      if (!b_ok) begin
        b_rdata_r <= {WORD_LEN{1'b0}};
      end else if (we && (waddr == b_raddr)) begin
        b_rdata_r <= wdata;
      end else begin
        b_rdata_r <= mem_r[b_raddr];
      end
    end
  end

  assign a_rdata = a_rdata_r;
  assign b_rdata = b_rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Instruction/data memory responder with INIT/READY sequencing, valid tracking and error pulses.
// Define MEM_RESPONDER_CLEAR_EN to zero the whole array during INIT.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WORD_LEN    = WORD_LEN_DEFAULT,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic [WORD_LEN-1:0] inst,
  output logic                i_valid,
  input  logic [WORD_LEN-1:0] d_addr,
  output logic [WORD_LEN-1:0] rdata,
  output logic                d_valid,
  input  logic                wen,
  input  logic [WORD_LEN-1:0] wdata,
  output logic                ready,
  output logic                err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WORD_LEN-1:0] ADDR_LIMIT = WORD_LEN'(4 * DEPTH_WORDS);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [WORD_LEN-1:0] i_addr_r;
  logic [WORD_LEN-1:0] d_addr_r;
  logic                err_r;
  logic                err_nxt_s;
  logic                i_ok_s;
  logic                d_ok_s;
  logic                i_mis_s;
  logic                d_mis_s;
  logic                ready_s;
  logic                we_s;
  logic [AW-1:0]       waddr_s;
  logic [WORD_LEN-1:0] wdata_s;
  logic [AW-1:0]       i_idx_s;
  logic [AW-1:0]       d_idx_s;

  assign i_idx_s   = i_addr[AW+1:2];
  assign d_idx_s   = d_addr[AW+1:2];
  assign i_ok_s    = (i_addr < ADDR_LIMIT);
  assign d_ok_s    = (d_addr < ADDR_LIMIT);
  assign i_mis_s   = (i_addr[1:0] != 2'b00);
  assign d_mis_s   = (d_addr[1:0] != 2'b00);
  assign ready_s   = (state_r == READY);
  assign err_nxt_s = ready_s & (i_mis_s | ~i_ok_s | ~d_ok_s | (wen & d_mis_s));

`ifdef MEM_RESPONDER_CLEAR_EN
  logic [AW-1:0] cnt_r;

  // Clear counter walks every word once while in INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {AW{1'b0}};
    end else if (state_r == INIT) begin
      cnt_r <= cnt_r + AW'(1);
    end else begin
      cnt_r <= {AW{1'b0}};
    end
  end

  // Write port: zero-fill during INIT, user writes once READY; nothing lands while rst is high.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = d_idx_s;
    wdata_s = wdata;
    if (state_r == INIT) begin
      we_s    = ~rst;
      waddr_s = cnt_r;
      wdata_s = {WORD_LEN{1'b0}};
    end else begin
      we_s    = ~rst & wen & d_ok_s;
      waddr_s = d_idx_s;
      wdata_s = wdata;
    end
  end
`else
  // Write port: user writes only once READY; nothing lands while rst is high.
  always_comb begin
    we_s    = ~rst & ready_s & wen & d_ok_s;
    waddr_s = d_idx_s;
    wdata_s = wdata;
  end
`endif

  // Next-state logic for INIT -> READY sequencing.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      INIT: begin
`ifdef MEM_RESPONDER_CLEAR_EN
        if (cnt_r == AW'(DEPTH_WORDS - 1)) begin
          state_nxt_s = READY;
        end else begin
          state_nxt_s = INIT;
        end
`else
        state_nxt_s = READY;
`endif
      end
      READY:   state_nxt_s = READY;
      default: state_nxt_s = INIT;
    endcase
  end

  // State, sampled addresses and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= INIT;
      i_addr_r <= {WORD_LEN{1'b0}};
      d_addr_r <= {WORD_LEN{1'b0}};
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      i_addr_r <= i_addr;
      d_addr_r <= d_addr;
      err_r    <= err_nxt_s;
    end
  end

  mem_array #(
    .WORD_LEN    (WORD_LEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (we_s),
    .waddr   (waddr_s),
    .wdata   (wdata_s),
    .a_raddr (i_idx_s),
    .a_ok    (i_ok_s),
    .a_rdata (inst),
    .b_raddr (d_idx_s),
    .b_ok    (d_ok_s),
    .b_rdata (rdata)
  );

  assign ready   = ready_s;
  assign i_valid = ready_s & (i_addr_r == i_addr);
  assign d_valid = ready_s & (d_addr_r == d_addr);
  assign err     = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder; honours MEM_RESPONDER_CLEAR_EN when defined.
module tb_mem_responder;

  localparam int WL = 32;
  localparam int DW = 4096;
  localparam logic [31:0] LIMIT = 32'(4 * DW);
`ifdef MEM_RESPONDER_CLEAR_EN
  localparam int READY_CYCLES = DW;
`else
  localparam int READY_CYCLES = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WL-1:0] i_addr = 32'h0;
  logic [WL-1:0] d_addr = 32'h0;
  logic          wen = 1'b0;
  logic [WL-1:0] wdata = 32'h0;
  logic [WL-1:0] inst;
  logic [WL-1:0] rdata;
  logic          i_valid;
  logic          d_valid;
  logic          ready;
  logic          err;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference contents: words written so far; all_zero marks a freshly cleared array.
  logic [31:0] model [int];
  bit          all_zero = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.WORD_LEN(WL), .DEPTH_WORDS(DW)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .inst(inst), .i_valid(i_valid),
    .d_addr(d_addr), .rdata(rdata), .d_valid(d_valid), .wen(wen),
    .wdata(wdata), .ready(ready), .err(err)
  );

  function automatic bit model_get(input logic [31:0] addr, output logic [31:0] val);
    int idx;
    val = 32'h0;
    if (addr >= LIMIT) return 1'b1;
    idx = int'(addr / 4);
    if (model.exists(idx)) begin
      val = model[idx];
      return 1'b1;
    end
    return all_zero;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] val);
    if (addr < LIMIT) model[int'(addr / 4)] = val;
  endfunction

  function automatic bit exp_err(input logic [31:0] ia, input logic [31:0] da, input logic w);
    return (ia % 4 != 0) || (ia >= LIMIT) || (da >= LIMIT) || (w && (da % 4 != 0));
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) * 32'd4;
    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
    if ($urandom_range(0, 9) == 0) a = a + (($urandom_range(0, 1) == 0) ? 32'h0000_4000 : 32'hFFFF_0000);
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 5000) begin
      step();
      cycles++;
    end
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    wen = 1'b0;
    step();
    step();
    rst = 1'b0;
`ifdef MEM_RESPONDER_CLEAR_EN
    model.delete();
    all_zero = 1'b1;
`endif
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] val);
    d_addr = addr;
    wdata  = val;
    wen    = 1'b1;
    model_write(addr, val);
    step();
    wen = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rst    = 1'b1;
    i_addr = 32'h0000_0008;
    d_addr = 32'h0000_000C;
    wen    = 1'b1;
    wdata  = 32'hCAFE_F00D;
    step();
    step();
    n_cmp += 6;
    if (inst !== 32'h0)   begin n_mis++; $display("FAIL reset_inst got=%h want=0", inst); end
    if (rdata !== 32'h0)  begin n_mis++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    if (i_valid !== 1'b0) begin n_mis++; $display("FAIL reset_i_valid got=%b want=0", i_valid); end
    if (d_valid !== 1'b0) begin n_mis++; $display("FAIL reset_d_valid got=%b want=0", d_valid); end
    if (ready !== 1'b0)   begin n_mis++; $display("FAIL reset_ready got=%b want=0", ready); end
    if (err !== 1'b0)     begin n_mis++; $display("FAIL reset_err got=%b want=0", err); end
    wen = 1'b0;
    rst = 1'b0;
`ifdef MEM_RESPONDER_CLEAR_EN
    all_zero = 1'b1;
`endif
    wait_ready(cyc);
    n_cmp++;
    if (cyc != READY_CYCLES) begin n_mis++; $display("FAIL reset_ready_latency got=%0d want=%0d", cyc, READY_CYCLES); end
  endtask

  task automatic test_clear();
    int cyc;
    logic [31:0] want;
    do_write(32'h0000_0014, 32'hDEAD_BEEF);
    step();
    n_cmp++;
    if (rdata !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL clear_preload got=%h want=deadbeef", rdata); end
    hold_reset();
    wait_ready(cyc);
    n_cmp++;
    if (cyc != READY_CYCLES) begin n_mis++; $display("FAIL clear_latency got=%0d want=%0d", cyc, READY_CYCLES); end
    d_addr = 32'h0000_0014;
    step();
`ifdef MEM_RESPONDER_CLEAR_EN
    want = 32'h0;
`else
    want = 32'hDEAD_BEEF;
`endif
    n_cmp++;
    if (rdata !== want) begin n_mis++; $display("FAIL clear_word5 got=%h want=%h", rdata, want); end
  endtask

`ifdef MEM_RESPONDER_CLEAR_EN
  task automatic test_mid_clear();
    int cyc;
    int early;
    rst = 1'b1;
    step();
    rst = 1'b0;
    early = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ready !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin n_mis++; $display("FAIL midclear_early_ready got=%0d want=0", early); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(cyc);
    n_cmp++;
    if (cyc != DW) begin n_mis++; $display("FAIL midclear_restart got=%0d want=%0d", cyc, DW); end
  endtask
`endif

  task automatic test_reset_abort();
    int cyc;
    logic [31:0] want;
    logic [31:0] got;
    do_write(32'h0000_001C, 32'h1111_2222);
    d_addr = 32'h0000_001C;
    wdata  = 32'h3333_4444;
    wen    = 1'b1;
    rst    = 1'b1;
    step();
    step();
    wen = 1'b0;
    rst = 1'b0;
`ifdef MEM_RESPONDER_CLEAR_EN
    model.delete();
    all_zero = 1'b1;
`endif
    wait_ready(cyc);
    step();
    void'(model_get(32'h0000_001C, want));
    got = rdata;
    n_cmp++;
    if (got !== want) begin n_mis++; $display("FAIL reset_abort got=%h want=%h", got, want); end
  endtask

  task automatic test_write_read();
    do_write(32'h0000_0100, 32'h1234_5678);
    n_cmp += 3;
    if (rdata !== 32'h1234_5678) begin n_mis++; $display("FAIL wr_rd_data got=%h want=12345678", rdata); end
    if (d_valid !== 1'b1) begin n_mis++; $display("FAIL wr_rd_valid got=%b want=1", d_valid); end
    if (err !== 1'b0) begin n_mis++; $display("FAIL wr_rd_err got=%b want=0", err); end
  endtask

  task automatic test_write_first();
    i_addr = 32'h0000_0040;
    do_write(32'h0000_0040, 32'hA5A5_A5A5);
    n_cmp += 2;
    if (inst !== 32'hA5A5_A5A5) begin n_mis++; $display("FAIL write_first_inst got=%h want=a5a5a5a5", inst); end
    if (rdata !== 32'hA5A5_A5A5) begin n_mis++; $display("FAIL write_first_rdata got=%h want=a5a5a5a5", rdata); end
  endtask

  task automatic test_valid_handshake();
    do_write(32'h0000_0000, 32'h0BAD_0000);
    do_write(32'h0000_0004, 32'h0BAD_0004);
    d_addr = 32'h0000_0000;
    step();
    n_cmp++;
    if (d_valid !== 1'b1) begin n_mis++; $display("FAIL hs_steady got=%b want=1", d_valid); end
    d_addr = 32'h0000_0004;
    #1;
    n_cmp++;
    if (d_valid !== 1'b0) begin n_mis++; $display("FAIL hs_change got=%b want=0", d_valid); end
    step();
    n_cmp += 2;
    if (d_valid !== 1'b1) begin n_mis++; $display("FAIL hs_settle got=%b want=1", d_valid); end
    if (rdata !== 32'h0BAD_0004) begin n_mis++; $display("FAIL hs_data got=%h want=0bad0004", rdata); end
  endtask

  task automatic test_out_of_range();
    i_addr = 32'h0000_0000;
    do_write(32'h0000_0000, 32'h5555_AAAA);
    d_addr = 32'h0000_4000;
    wdata  = 32'hFFFF_FFFF;
    wen    = 1'b1;
    step();
    wen = 1'b0;
    n_cmp += 2;
    if (err !== 1'b1) begin n_mis++; $display("FAIL oor_err got=%b want=1", err); end
    if (rdata !== 32'h0) begin n_mis++; $display("FAIL oor_rdata got=%h want=0", rdata); end
    d_addr = 32'h0000_0000;
    step();
    n_cmp += 2;
    if (err !== 1'b0) begin n_mis++; $display("FAIL oor_err_end got=%b want=0", err); end
    if (rdata !== 32'h5555_AAAA) begin n_mis++; $display("FAIL oor_word0 got=%h want=5555aaaa", rdata); end
  endtask

  task automatic test_random();
    logic [31:0] pi;
    logic [31:0] pd;
    logic [31:0] ev;
    bit          e;
    for (int k = 0; k < 16; k++) do_write(32'(k * 4), $urandom());
    for (int n = 0; n < 400; n++) begin
      pi     = i_addr;
      pd     = d_addr;
      i_addr = rand_addr();
      d_addr = rand_addr();
      wen    = ($urandom_range(0, 2) == 0);
      wdata  = $urandom();
      #1;
      n_cmp += 2;
      if (i_valid !== (i_addr == pi)) begin n_mis++; $display("FAIL rnd_i_valid n=%0d got=%b want=%b", n, i_valid, (i_addr == pi)); end
      if (d_valid !== (d_addr == pd)) begin n_mis++; $display("FAIL rnd_d_valid n=%0d got=%b want=%b", n, d_valid, (d_addr == pd)); end
      e = exp_err(i_addr, d_addr, wen);
      if (wen) model_write(d_addr, wdata);
      step();
      n_cmp++;
      if (err !== e) begin n_mis++; $display("FAIL rnd_err n=%0d got=%b want=%b", n, err, e); end
      if (model_get(i_addr, ev)) begin
        n_cmp++;
        if (inst !== ev) begin n_mis++; $display("FAIL rnd_inst n=%0d addr=%h got=%h want=%h", n, i_addr, inst, ev); end
      end
      if (model_get(d_addr, ev)) begin
        n_cmp++;
        if (rdata !== ev) begin n_mis++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h want=%h", n, d_addr, rdata, ev); end
      end
    end
    wen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_first();
    test_valid_handshake();
    test_out_of_range();
    test_random();
    test_clear();
`ifdef MEM_RESPONDER_CLEAR_EN
    test_mid_clear();
`endif
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
